// File: rtl/traffic_conflict_monitor_pkg.sv
// Shared definitions for the traffic conflict monitor: lamp encodings,
// fault cause codes, FSM state type and small lamp-vector helpers.
package traffic_conflict_monitor_pkg;

    // Lamp encodings (one-hot: red, yellow, green)
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    // Fault cause codes; a lower number wins when several apply together
    localparam logic [2:0] FC_NONE         = 3'd0;
    localparam logic [2:0] FC_ONEHOT       = 3'd1;
    localparam logic [2:0] FC_CONFLICT     = 3'd2;
    localparam logic [2:0] FC_GREEN_RED    = 3'd3;
    localparam logic [2:0] FC_SHORT_YELLOW = 3'd4;

    // Approach indices into the packed lamp arrays
    localparam int NUM_APPROACH = 4;
    localparam int AP_M1 = 0;
    localparam int AP_S  = 1;
    localparam int AP_M2 = 2;
    localparam int AP_MT = 3;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        LATCHED = 2'd1,
        RECOVER = 2'd2
    } state_e;

    // A lamp vector is legal only if it is exactly one of the three colours
    function automatic logic is_one_hot(input logic [2:0] v);
        return (v == RED) || (v == YELLOW) || (v == GREEN);
    endfunction

    // Non-red means showing yellow or green
    function automatic logic is_non_red(input logic [2:0] v);
        return (v == YELLOW) || (v == GREEN);
    endfunction

endpackage

// File: rtl/yellow_timer_check.sv
// Per-approach transition checker: remembers the previous lamp vector and
// counts consecutive yellow cycles, flagging green->red jumps and yellow
// phases that end before MIN_YELLOW cycles.
module yellow_timer_check #(
    parameter int MIN_YELLOW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light,
    output logic       green_to_red,
    output logic       short_yellow
);
    import traffic_conflict_monitor_pkg::*;

    localparam int CNT_W = (MIN_YELLOW < 1) ? 1 : $clog2(MIN_YELLOW + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [2:0]       prev_q;
    logic [2:0]       prev_d;
    logic [CNT_W-1:0] yel_cnt_q;
    logic [CNT_W-1:0] yel_cnt_d;

    assign prev_d = light;

    // Yellow-run counter: count up while yellow, saturate, clear otherwise
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        yel_cnt_d = yel_cnt_q;
        if (light == YELLOW) begin
            if (yel_cnt_q != CNT_MAX) begin
                yel_cnt_d = yel_cnt_q + CNT_ONE;
            end
        end else begin
            yel_cnt_d = '0;
        end
    end

    // Previous-input and yellow-run registers update every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= RED;
            yel_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            prev_q    <= prev_d;
            yel_cnt_q <= yel_cnt_d;
        end
    end

    assign green_to_red = (prev_q == GREEN) && (light == RED);
    assign short_yellow = (prev_q == YELLOW) && (light == RED) && (yel_cnt_q < CNT_MAX);

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the signal controller and the lamp drivers. Passes the
// controller's lamp vectors through one register while they are legal; on any
// violation it forces all approaches red, latches a cause code and waits for
// an operator clear followed by an enforced all-red hold.
module traffic_conflict_monitor #(
    parameter int MIN_YELLOW  = 2,
    parameter int ALLRED_HOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_S,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic       fault_clear,
    output logic [2:0] safe_M1,
    output logic [2:0] safe_S,
    output logic [2:0] safe_M2,
    output logic [2:0] safe_MT,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] fault_count
);
    import traffic_conflict_monitor_pkg::*;

    localparam int HOLD_W = (ALLRED_HOLD < 1) ? 1 : $clog2(ALLRED_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ALLRED_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [NUM_APPROACH-1:0][2:0] light;
    logic [NUM_APPROACH-1:0]      one_hot_ok;
    logic [NUM_APPROACH-1:0]      non_red;
    logic [NUM_APPROACH-1:0]      green_to_red;
    logic [NUM_APPROACH-1:0]      short_yellow;

    logic       conflict;
    logic       all_red;
    logic       violation;
    logic [2:0] viol_code;

    state_e                       state_q, state_d;
    logic [NUM_APPROACH-1:0][2:0] safe_q, safe_d;
    logic                         fault_q, fault_d;
    logic [2:0]                   fault_code_q, fault_code_d;
    logic [7:0]                   fault_count_q, fault_count_d;
    logic [7:0]                   fault_count_inc;
    logic [HOLD_W-1:0]            hold_q, hold_d;

    assign light = {light_MT, light_M2, light_S, light_M1};

    for (genvar i = 0; i < NUM_APPROACH; i++) begin : g_approach
        yellow_timer_check #(
            .MIN_YELLOW (MIN_YELLOW)
        ) u_yellow_timer_check (
            .clk          (clk),
            .rst          (rst),
            .light        (light[i]),
            .green_to_red (green_to_red[i]),
            .short_yellow (short_yellow[i])
        );

        assign one_hot_ok[i] = is_one_hot(light[i]);
        assign non_red[i]    = is_non_red(light[i]);
    end

    // S conflicts with every main approach; the turn lane conflicts with M2.
    // M1 and M2 are opposing through movements and may run together.
    assign conflict = (non_red[AP_S] && (non_red[AP_M1] || non_red[AP_M2] || non_red[AP_MT]))
                   || (non_red[AP_MT] && non_red[AP_M2]);

    assign all_red = (light[AP_M1] == RED) && (light[AP_S] == RED)
                  && (light[AP_M2] == RED) && (light[AP_MT] == RED);

    // Violation classification, lowest code number wins
    always_comb begin
        viol_code = FC_NONE;
        if (!(&one_hot_ok)) begin
            viol_code = FC_ONEHOT;
        end else if (conflict) begin
            viol_code = FC_CONFLICT;
        end else if (|green_to_red) begin
            viol_code = FC_GREEN_RED;
        end else if (|short_yellow) begin
            viol_code = FC_SHORT_YELLOW;
        end
    end

    assign violation       = (viol_code != FC_NONE);
    assign fault_count_inc = (fault_count_q == 8'hFF) ? fault_count_q : fault_count_q + 8'd1;

    // Fault FSM next-state and registered-output selection
    always_comb begin
        state_d       = state_q;
        safe_d        = {NUM_APPROACH{RED}};
        fault_d       = fault_q;
        fault_code_d  = fault_code_q;
        fault_count_d = fault_count_q;
        hold_d        = hold_q;

        unique case (state_q)
            MONITOR: begin
                if (violation) begin
                    state_d       = LATCHED;
                    fault_d       = 1'b1;
                    fault_code_d  = viol_code;
                    fault_count_d = fault_count_inc;
                end else begin
                    safe_d  = light;
                    fault_d = 1'b0;
                end
            end

            LATCHED: begin
                fault_d = 1'b1;
                if (fault_clear && all_red) begin
                    state_d = RECOVER;
                    hold_d  = HOLD_LOAD;
                end
            end

            RECOVER: begin
                fault_d = 1'b1;
                if (violation || !all_red) begin
                    // A legal but non-red lamp during the enforced all-red hold
                    // is reported as a conflict with that hold.
                    state_d       = LATCHED;
                    fault_code_d  = violation ? viol_code : FC_CONFLICT;
                    fault_count_d = fault_count_inc;
                    hold_d        = '0;
                end else if (hold_q <= HOLD_ONE) begin
                    state_d      = MONITOR;
                    fault_d      = 1'b0;
                    fault_code_d = FC_NONE;
                    hold_d       = '0;
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end

            default: begin
                state_d = MONITOR;
            end
        endcase
    end

    // FSM state and registered lamp/fault outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= MONITOR;
            safe_q        <= {NUM_APPROACH{RED}};
            fault_q       <= 1'b0;
            fault_code_q  <= FC_NONE;
            fault_count_q <= 8'd0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            safe_q        <= safe_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
            fault_count_q <= fault_count_d;
            hold_q        <= hold_d;
        end
    end

    assign safe_M1     = safe_q[AP_M1];
    assign safe_S      = safe_q[AP_S];
    assign safe_M2     = safe_q[AP_M2];
    assign safe_MT     = safe_q[AP_MT];
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;
    assign fault_count = fault_count_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Self-checking bench for traffic_conflict_monitor. Each scenario task pushes
// the expected post-edge outputs to a scoreboard as it drives a cycle, then
// pops and compares once the DUT has registered that cycle.
module tb_traffic_conflict_monitor;
    import traffic_conflict_monitor_pkg::*;

    typedef struct packed {
        logic [2:0] m1;
        logic [2:0] s;
        logic [2:0] m2;
        logic [2:0] mt;
        logic       clr;
    } stim_t;

    typedef struct packed {
        logic [2:0] m1;
        logic [2:0] s;
        logic [2:0] m2;
        logic [2:0] mt;
        logic       fault;
        logic [2:0] code;
        logic [7:0] count;
    } obs_t;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] light_M1, light_S, light_M2, light_MT;
    logic       fault_clear;
    logic [2:0] safe_M1, safe_S, safe_M2, safe_MT;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] fault_count;

    obs_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    traffic_conflict_monitor #(
        .MIN_YELLOW  (2),
        .ALLRED_HOLD (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .light_M1    (light_M1),
        .light_S     (light_S),
        .light_M2    (light_M2),
        .light_MT    (light_MT),
        .fault_clear (fault_clear),
        .safe_M1     (safe_M1),
        .safe_S      (safe_S),
        .safe_M2     (safe_M2),
        .safe_MT     (safe_MT),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_count (fault_count)
    );

    function automatic stim_t st(input logic [2:0] m1, s, m2, mt, input logic clr);
        return '{m1: m1, s: s, m2: m2, mt: mt, clr: clr};
    endfunction

    function automatic obs_t ex(input logic [2:0] m1, s, m2, mt, input logic f,
                                input logic [2:0] code, input logic [7:0] count);
        return '{m1: m1, s: s, m2: m2, mt: mt, fault: f, code: code, count: count};
    endfunction

    // Expected outputs when the stage simply passes the lamps through
    function automatic obs_t follow(input stim_t s, input logic [7:0] count);
        return ex(s.m1, s.s, s.m2, s.mt, 1'b0, 3'd0, count);
    endfunction

    function automatic obs_t observe();
        return ex(safe_M1, safe_S, safe_M2, safe_MT, fault, fault_code, fault_count);
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("safe=%b/%b/%b/%b fault=%b code=%0d count=%0d",
                         o.m1, o.s, o.m2, o.mt, o.fault, o.code, o.count);
    endfunction

    // Drive one cycle of stimulus, record its expected result, let it register
    task automatic apply(input stim_t s, input obs_t e);
        light_M1    = s.m1;
        light_S     = s.s;
        light_M2    = s.m2;
        light_MT    = s.mt;
        fault_clear = s.clr;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        light_M1    = R;
        light_S     = R;
        light_M2    = R;
        light_MT    = R;
        fault_clear = 1'b0;
        rst         = 1'b1;
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        do_reset();
        got = observe();
        n_checks++;
        if (got !== ex(R, R, R, R, 1'b0, 3'd0, 8'd0))
            $display("FAIL reset: got %s, expected %s", fmt(got), fmt(ex(R, R, R, R, 1'b0, 3'd0, 8'd0)));
        else
            n_pass++;
    endtask

    task automatic test_legal_cycle();
        stim_t s_q[$];
        obs_t  got, exp_v;
        for (int i = 0; i < 5; i++) s_q.push_back(st(G, R, G, R, 1'b0));
        for (int i = 0; i < 2; i++) s_q.push_back(st(Y, R, Y, R, 1'b0));
        s_q.push_back(st(R, R, R, R, 1'b0));
        for (int i = 0; i < 3; i++) s_q.push_back(st(R, G, R, R, 1'b0));
        for (int i = 0; i < 2; i++) s_q.push_back(st(R, Y, R, R, 1'b0));
        s_q.push_back(st(R, R, R, R, 1'b0));
        for (int i = 0; i < s_q.size(); i++) begin
            apply(s_q[i], follow(s_q[i], 8'd0));
            exp_v = sb.pop_front();
            got   = observe();
            n_checks++;
            if (got !== exp_v)
                $display("FAIL legal_cycle[%0d]: got %s, expected %s", i, fmt(got), fmt(exp_v));
            else
                n_pass++;
        end
    endtask

    // Conflict latch, then clear while not all red and a second fault while latched
    task automatic test_conflict();
        stim_t s_q[$];
        obs_t  e_q[$];
        obs_t  got, exp_v;
        s_q.push_back(st(G, G, R, R, 1'b0));      e_q.push_back(ex(R, R, R, R, 1'b1, 3'd2, 8'd1));
        s_q.push_back(st(G, G, R, R, 1'b1));      e_q.push_back(ex(R, R, R, R, 1'b1, 3'd2, 8'd1));
        s_q.push_back(st(R, 3'b111, R, R, 1'b0)); e_q.push_back(ex(R, R, R, R, 1'b1, 3'd2, 8'd1));
        for (int i = 0; i < s_q.size(); i++) begin
            apply(s_q[i], e_q[i]);
            exp_v = sb.pop_front();
            got   = observe();
            n_checks++;
            if (got !== exp_v)
                $display("FAIL conflict[%0d]: got %s, expected %s", i, fmt(got), fmt(exp_v));
            else
                n_pass++;
        end
    endtask

    // Honoured clear, two all-red hold cycles, then pass-through resumes
    task automatic test_recovery();
        stim_t s_q[$];
        obs_t  e_q[$];
        obs_t  got, exp_v;
        s_q.push_back(st(R, R, R, R, 1'b0)); e_q.push_back(ex(R, R, R, R, 1'b1, 3'd2, 8'd1));
        s_q.push_back(st(R, R, R, R, 1'b1)); e_q.push_back(ex(R, R, R, R, 1'b1, 3'd2, 8'd1));
        s_q.push_back(st(R, R, R, R, 1'b0)); e_q.push_back(ex(R, R, R, R, 1'b1, 3'd2, 8'd1));
        s_q.push_back(st(R, R, R, R, 1'b0)); e_q.push_back(ex(R, R, R, R, 1'b0, 3'd0, 8'd1));
        s_q.push_back(st(G, R, G, R, 1'b0)); e_q.push_back(ex(G, R, G, R, 1'b0, 3'd0, 8'd1));
        s_q.push_back(st(Y, R, Y, R, 1'b0)); e_q.push_back(ex(Y, R, Y, R, 1'b0, 3'd0, 8'd1));
        s_q.push_back(st(Y, R, Y, R, 1'b0)); e_q.push_back(ex(Y, R, Y, R, 1'b0, 3'd0, 8'd1));
        s_q.push_back(st(R, R, R, R, 1'b1)); e_q.push_back(ex(R, R, R, R, 1'b0, 3'd0, 8'd1));
        for (int i = 0; i < s_q.size(); i++) begin
            apply(s_q[i], e_q[i]);
            exp_v = sb.pop_front();
            got   = observe();
            n_checks++;
            if (got !== exp_v)
                $display("FAIL recovery[%0d]: got %s, expected %s", i, fmt(got), fmt(exp_v));
            else
                n_pass++;
        end
    endtask

    // MT green straight to red (code 3), then recover
    task automatic test_green_red();
        stim_t s_q[$];
        obs_t  e_q[$];
        obs_t  got, exp_v;
        s_q.push_back(st(R, R, R, G, 1'b0)); e_q.push_back(ex(R, R, R, G, 1'b0, 3'd0, 8'd1));
        s_q.push_back(st(R, R, R, R, 1'b0)); e_q.push_back(ex(R, R, R, R, 1'b1, 3'd3, 8'd2));
        s_q.push_back(st(R, R, R, R, 1'b1)); e_q.push_back(ex(R, R, R, R, 1'b1, 3'd3, 8'd2));
        s_q.push_back(st(R, R, R, R, 1'b0)); e_q.push_back(ex(R, R, R, R, 1'b1, 3'd3, 8'd2));
        s_q.push_back(st(R, R, R, R, 1'b0)); e_q.push_back(ex(R, R, R, R, 1'b0, 3'd0, 8'd2));
        for (int i = 0; i < s_q.size(); i++) begin
            apply(s_q[i], e_q[i]);
            exp_v = sb.pop_front();
            got   = observe();
            n_checks++;
            if (got !== exp_v)
                $display("FAIL green_red[%0d]: got %s, expected %s", i, fmt(got), fmt(exp_v));
            else
                n_pass++;
        end
    endtask

    // M2 yellow for one cycle only (code 4), then recover
    task automatic test_short_yellow();
        stim_t s_q[$];
        obs_t  e_q[$];
        obs_t  got, exp_v;
        s_q.push_back(st(R, R, G, R, 1'b0)); e_q.push_back(ex(R, R, G, R, 1'b0, 3'd0, 8'd2));
        s_q.push_back(st(R, R, Y, R, 1'b0)); e_q.push_back(ex(R, R, Y, R, 1'b0, 3'd0, 8'd2));
        s_q.push_back(st(R, R, R, R, 1'b0)); e_q.push_back(ex(R, R, R, R, 1'b1, 3'd4, 8'd3));
        s_q.push_back(st(R, R, R, R, 1'b1)); e_q.push_back(ex(R, R, R, R, 1'b1, 3'd4, 8'd3));
        s_q.push_back(st(R, R, R, R, 1'b0)); e_q.push_back(ex(R, R, R, R, 1'b1, 3'd4, 8'd3));
        s_q.push_back(st(R, R, R, R, 1'b0)); e_q.push_back(ex(R, R, R, R, 1'b0, 3'd0, 8'd3));
        for (int i = 0; i < s_q.size(); i++) begin
            apply(s_q[i], e_q[i]);
            exp_v = sb.pop_front();
            got   = observe();
            n_checks++;
            if (got !== exp_v)
                $display("FAIL short_yellow[%0d]: got %s, expected %s", i, fmt(got), fmt(exp_v));
            else
                n_pass++;
        end
    endtask

    // Malformed S together with an MT/M2 conflict: code 1 wins
    task automatic test_priority();
        stim_t s_q[$];
        obs_t  e_q[$];
        obs_t  got, exp_v;
        s_q.push_back(st(R, 3'b011, G, G, 1'b0)); e_q.push_back(ex(R, R, R, R, 1'b1, 3'd1, 8'd4));
        s_q.push_back(st(R, R, R, R, 1'b1));      e_q.push_back(ex(R, R, R, R, 1'b1, 3'd1, 8'd4));
        s_q.push_back(st(R, R, R, R, 1'b0));      e_q.push_back(ex(R, R, R, R, 1'b1, 3'd1, 8'd4));
        s_q.push_back(st(R, R, R, R, 1'b0));      e_q.push_back(ex(R, R, R, R, 1'b0, 3'd0, 8'd4));
        for (int i = 0; i < s_q.size(); i++) begin
            apply(s_q[i], e_q[i]);
            exp_v = sb.pop_front();
            got   = observe();
            n_checks++;
            if (got !== exp_v)
                $display("FAIL priority[%0d]: got %s, expected %s", i, fmt(got), fmt(exp_v));
            else
                n_pass++;
        end
    endtask

    // 260 fault/recover rounds: the fault counter must stop at 255
    task automatic test_saturation();
        obs_t       got, exp_v;
        logic [7:0] cnt;
        do_reset();
        for (int k = 1; k <= 260; k++) begin
            cnt = (k > 255) ? 8'd255 : 8'(k);
            apply(st(G, G, R, R, 1'b0), ex(R, R, R, R, 1'b1, 3'd2, cnt));
            apply(st(R, R, R, R, 1'b1), ex(R, R, R, R, 1'b1, 3'd2, cnt));
            apply(st(R, R, R, R, 1'b0), ex(R, R, R, R, 1'b1, 3'd2, cnt));
            apply(st(R, R, R, R, 1'b0), ex(R, R, R, R, 1'b0, 3'd0, cnt));
            // Only the latch cycle of each round is compared; the rest drain the scoreboard
            exp_v = sb.pop_front();
            void'(sb.pop_front());
            void'(sb.pop_front());
            void'(sb.pop_front());
            got = '0;
            if (k == 1 || k >= 254) begin
                got = ex(safe_M1, safe_S, safe_M2, safe_MT, 1'b1, 3'd2, fault_count);
                n_checks++;
                if (got.count !== exp_v.count)
                    $display("FAIL saturation[%0d]: got count=%0d, expected count=%0d", k, got.count, exp_v.count);
                else
                    n_pass++;
            end
        end
    endtask

    // Repeat violation during the all-red hold re-latches with a new code
    task automatic test_recover_violation();
        stim_t s_q[$];
        obs_t  e_q[$];
        obs_t  got, exp_v;
        do_reset();
        s_q.push_back(st(G, G, R, R, 1'b0));      e_q.push_back(ex(R, R, R, R, 1'b1, 3'd2, 8'd1));
        s_q.push_back(st(R, R, R, R, 1'b1));      e_q.push_back(ex(R, R, R, R, 1'b1, 3'd2, 8'd1));
        s_q.push_back(st(R, 3'b110, R, R, 1'b0)); e_q.push_back(ex(R, R, R, R, 1'b1, 3'd1, 8'd2));
        s_q.push_back(st(R, R, R, R, 1'b0));      e_q.push_back(ex(R, R, R, R, 1'b1, 3'd1, 8'd2));
        for (int i = 0; i < s_q.size(); i++) begin
            apply(s_q[i], e_q[i]);
            exp_v = sb.pop_front();
            got   = observe();
            n_checks++;
            if (got !== exp_v)
                $display("FAIL recover_violation[%0d]: got %s, expected %s", i, fmt(got), fmt(exp_v));
            else
                n_pass++;
        end
    endtask

    // Reset between edges while latched, then the first transitions are checked normally
    task automatic test_async_reset();
        obs_t got, exp_v;
        #3;
        rst = 1'b1;
        #1;
        got = observe();
        n_checks++;
        if (got !== ex(R, R, R, R, 1'b0, 3'd0, 8'd0))
            $display("FAIL async_reset: got %s, expected %s", fmt(got), fmt(ex(R, R, R, R, 1'b0, 3'd0, 8'd0)));
        else
            n_pass++;
        light_M1    = R;
        light_S     = R;
        light_M2    = R;
        light_MT    = R;
        fault_clear = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(st(G, R, R, R, 1'b0), ex(G, R, R, R, 1'b0, 3'd0, 8'd0));
        exp_v = sb.pop_front();
        got   = observe();
        n_checks++;
        if (got !== exp_v)
            $display("FAIL post_reset_follow: got %s, expected %s", fmt(got), fmt(exp_v));
        else
            n_pass++;
        apply(st(R, R, R, R, 1'b0), ex(R, R, R, R, 1'b1, 3'd3, 8'd1));
        exp_v = sb.pop_front();
        got   = observe();
        n_checks++;
        if (got !== exp_v)
            $display("FAIL post_reset_green_red: got %s, expected %s", fmt(got), fmt(exp_v));
        else
            n_pass++;
    endtask

    initial begin
        rst         = 1'b1;
        light_M1    = R;
        light_S     = R;
        light_M2    = R;
        light_MT    = R;
        fault_clear = 1'b0;
        test_reset();
        test_legal_cycle();
        test_conflict();
        test_recovery();
        test_green_red();
        test_short_yellow();
        test_priority();
        test_saturation();
        test_recover_violation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/traffic_conflict_monitor.md
TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001 Parameter MIN_YELLOW, default 2: minimum consecutive yellow cycles before any approach may go yellow->red.
REQ-002 Parameter ALLRED_HOLD, default 2: all-red cycles enforced after a fault clear before monitoring resumes.
REQ-003 clk  input  1  system clock, 1 s period; all timing below is in clk cycles.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 light_M1, light_S, light_M2, light_MT  input  3 each  controller light vectors: 3'b100 red, 3'b010 yellow, 3'b001 green.
REQ-006 fault_clear  input  1  single-cycle operator clear request.
REQ-007 safe_M1, safe_S, safe_M2, safe_MT  output  3 each  registered lamp drive, same encoding as inputs.
REQ-008 fault  output  1  high while a fault is latched or recovery is in progress.
REQ-009 fault_code  output  3  cause of the most recent latched fault; 0 = none.
REQ-010 fault_count  output  8  number of faults latched since reset; saturates at 255.

Function
REQ-011 The block is a downstream stage: it consumes the controller's light vectors and produces the lamp drive.
REQ-012 Violation checks are combinational on the current inputs plus the previous-cycle input registers.
REQ-013 Code 1: any input vector that is not one-hot.
REQ-014 Code 2: a green-conflict pair, where non-red means yellow or green.
REQ-015 Code 2 pairs: S non-red with any of M1, M2 or MT non-red; MT non-red with M2 non-red.
REQ-016 M1 and M2 non-red together is legal.
REQ-017 Code 3: any approach changing green->red directly in one cycle.
REQ-018 Code 4: an approach going yellow->red after fewer than MIN_YELLOW consecutive yellow cycles.
REQ-019 When several codes apply in the same cycle, fault_code takes the lowest code number.
REQ-020 Each approach has a yellow-run counter: it increments while the input is yellow, saturates at MIN_YELLOW, and clears on any non-yellow input.
REQ-021 The FSM has states MONITOR, LATCHED and RECOVER.
REQ-022 MONITOR: safe_X follows light_X with 1-cycle latency.
REQ-023 MONITOR: a violation in cycle N gives state LATCHED, all safe_X = red, fault=1 and the code in cycle N+1.
REQ-024 MONITOR: on that same violation, fault_count increments once.
REQ-025 LATCHED: all safe_X are held red and fault_code is held.
REQ-026 LATCHED: fault_clear is honoured only if all four inputs are red in that cycle; otherwise it is ignored.
REQ-027 LATCHED: an honoured fault_clear moves the FSM to RECOVER and loads the hold counter with ALLRED_HOLD.
REQ-028 RECOVER: all safe_X stay red and fault stays 1 while the hold counter decrements.
REQ-029 RECOVER: when the counter reaches 0, the FSM enters MONITOR with fault=0 and fault_code=0, and safe_X follows the next cycle.
REQ-030 RECOVER: any violation, or any non-red input, returns the FSM to LATCHED with a new code, and fault_count increments.
REQ-031 Faults arriving while already LATCHED do not change fault_code or fault_count.
REQ-032 fault_clear asserted in MONITOR or RECOVER has no effect.
REQ-033 The previous-input registers and yellow-run counters update every cycle in all states.
REQ-034 Code 3 and code 4 checks are therefore valid on the first cycle after a return to MONITOR.

Reset
REQ-035 rst asynchronously sets state MONITOR, all safe_X = 3'b100, fault=0, fault_code=0 and fault_count=0.
REQ-036 rst also sets all previous-input registers to red and all yellow-run counters and the hold counter to 0.
REQ-037 rst asserted mid-fault discards the latched fault; counts do not persist.
REQ-038 After reset release, the first red-to-anything transition is checked normally.

Structure
REQ-039 A shared package holds the light encodings RED, YELLOW and GREEN, the fault-code constants 0-4 and the FSM state type.
REQ-040 The controller and its testbench reuse the same package.
REQ-041 The per-approach yellow-run counter plus the code 3/code 4 transition check is one sub-module, yellow_timer_check.
REQ-042 yellow_timer_check is instantiated four times.
REQ-043 Conflict checking, the fault FSM and output muxing stay in the top level.

Verification
REQ-044 Legal cycle M1/M2 green 5, yellow 2, red; then S green -> safe_X equals inputs delayed 1 cycle; fault stays 0.
REQ-045 S green with M1 green in cycle N -> cycle N+1 all safe_X = 3'b100, fault=1, fault_code=2, fault_count=1.
REQ-046 MT green -> red with no yellow -> fault_code=3.
REQ-047 M2 yellow for 1 cycle then red, with MIN_YELLOW=2 -> fault_code=4.
REQ-048 light_S=3'b011 while S also conflicts -> fault_code=1 (priority).
REQ-049 Recovery: fault_clear pulsed while M1 green -> ignored.
REQ-050 Recovery: all inputs red, then fault_clear -> 2 all-red cycles with fault=1, then fault=0 and outputs follow.
REQ-051 Recovery: a repeat violation during RECOVER -> LATCHED and fault_count=2.
REQ-052 rst asserted mid-LATCHED, asynchronously between clock edges -> outputs red and counters 0 immediately.
